count_capture: RTL
==================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter: DEPTH, default 4, number of FIFO entries; legal values 2, 4, 8.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous active-low reset; clears all state while low.
REQ-004 Port: up_cnt  input  4  up-count value from the counter stage, sampled each clk.
REQ-005 Port: down_cnt  input  4  down-count value from the counter stage, sampled with up_cnt.
REQ-006 Port: match_val  input  4  up_cnt value that raises a match event.
REQ-007 Port: cap_en  input  1  enables match-event detection when high.
REQ-008 Port: clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 Port: out_valid  output  1  head FIFO entry is valid.
REQ-010 Port: out_ready  input  1  consumer accepts the head entry.
REQ-011 Port: out_data  output  9  head entry {type, up[3:0], down[3:0]}; type 0 = match, 1 = wrap.
REQ-012 Port: fill  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-013 Port: overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 The block SHALL register up_cnt each cycle into prev_up and SHALL set prev_ok high on the first rising edge after reset release.
REQ-015 While prev_ok is low, the block SHALL raise no events.
REQ-016 A match event SHALL fire when cap_en=1, up_cnt==match_val, and up_cnt!=prev_up (once per arrival, never while the value holds).
REQ-017 A wrap event SHALL fire when prev_up==4'hF and up_cnt==4'h0, independent of cap_en (only when compiled in, see REQ-028).
REQ-018 On a simultaneous match and wrap, the block SHALL write one entry, with type=1.
REQ-019 An event SHALL write {type, up_cnt, down_cnt} as sampled in cycle N; the entry SHALL be visible at out_data/out_valid in cycle N+1 when the FIFO was empty.
REQ-020 out_valid SHALL equal (fill!=0); out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1; the next entry SHALL appear the following cycle.
REQ-022 An event with fill==DEPTH and no same-cycle pop SHALL be dropped and SHALL set overflow; FIFO contents SHALL be unchanged.
REQ-023 An event with fill==DEPTH and a same-cycle pop SHALL be accepted; fill SHALL remain DEPTH.
REQ-024 A simultaneous push and pop at any fill SHALL leave fill unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 clr_ovf=1 SHALL clear overflow next edge; a same-cycle drop SHALL win and leave overflow=1.

Reset
REQ-026 While rst=0: fill=0, out_valid=0, overflow=0, out_data=9'h000, prev_up=0, prev_ok=0, and both pointers=0, all asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; no event SHALL be raised on the first edge after release.

Configuration
REQ-028 Macro COUNT_CAPTURE_WRAP_EN: when defined, wrap detection per REQ-017/018 SHALL be built in; when undefined, no wrap logic SHALL exist, type SHALL always be 0, and only match events SHALL be captured.

Verification
REQ-029 Bench SHALL cover: reset release, match_val=4'h5, cap_en=1, up_cnt stepping 0..6 with down_cnt=4'hF -> exactly one entry 9'h05F, out_valid high one cycle after up_cnt=5 is sampled.
REQ-030 Bench SHALL cover: up_cnt held at 5 for 10 cycles, match_val=5 -> a single entry only; fill=1.
REQ-031 Bench SHALL cover (WRAP_EN defined): up_cnt 4'hE, 4'hF, 4'h0, down_cnt=4'hB, match_val=4'h0 -> one entry 9'h10B.
REQ-032 Bench SHALL cover: DEPTH=4, out_ready=0, five match events -> fill=4, overflow=1, the first four entries intact in order; clr_ovf pulse -> overflow=0.
REQ-033 Bench SHALL cover: FIFO full, an event coinciding with out_ready=1 -> the event is accepted, fill stays 4, overflow stays 0.
REQ-034 Bench SHALL cover: rst pulsed low with fill=3 -> fill=0 and out_valid=0 immediately; with up_cnt==match_val at release, no entry is written on the first edge.

Source files
------------

// File: rtl/count_capture.sv
// Captures up/down counter snapshots on match (and optionally wrap) events into a small FIFO.
// Define COUNT_CAPTURE_WRAP_EN to build in 4'hF -> 4'h0 wrap detection on up_cnt.
module count_capture #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               up_cnt,
    input  logic [3:0]               down_cnt,
    input  logic [3:0]               match_val,
    input  logic                     cap_en,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8:0]               out_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [3:0]    prev_up_reg;
    logic          prev_ok_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [FW-1:0] fill_reg;
    logic [FW-1:0] fill_next;
    logic          overflow_reg;
    logic [8:0]    mem [DEPTH];

    logic          match_hit;
    logic          event_hit;
    logic          event_type;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [8:0]    wr_entry;

    // A match fires only on arrival at match_val, never while the value is held.
    assign match_hit = prev_ok_reg && cap_en && (up_cnt == match_val)
                       && (up_cnt != prev_up_reg);

`ifdef COUNT_CAPTURE_WRAP_EN
    logic wrap_hit;
    assign wrap_hit   = prev_ok_reg && (prev_up_reg == 4'hF) && (up_cnt == 4'h0);
    assign event_hit  = match_hit || wrap_hit;
    assign event_type = wrap_hit;
`else
    assign event_hit  = match_hit;
    assign event_type = 1'b0;
`endif

    assign wr_entry  = {event_type, up_cnt, down_cnt};
    assign fifo_full = (fill_reg == FW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign push      = event_hit && (!fifo_full || pop);
    assign drop      = event_hit && fifo_full && !pop;

    always_comb begin
        fill_next = fill_reg;
        if (push && !pop) begin
            fill_next = fill_reg + FW'(1);
        end else if (pop && !push) begin
            fill_next = fill_reg - FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_up_reg  <= 4'h0;
            prev_ok_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            prev_up_reg <= up_cnt;
            prev_ok_reg <= 1'b1;
            fill_reg    <= fill_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    assign out_valid = (fill_reg != '0);
    assign out_data  = out_valid ? mem[rd_ptr_reg] : 9'h000;
    assign fill      = fill_reg;
    assign overflow  = overflow_reg;

endmodule
